up_down_counter_bounded: RTL and testbench

UP_DOWN_COUNTER_BOUNDED -- requirements
Module: up_down_counter_bounded

---
 rtl/up_down_counter_bounded.sv | 130 +++++++++++++
 tb/tb_up_down_counter_bounded.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_down_counter_bounded.sv
// ---------------------------------------------------------------------------
// up_down_counter_bounded
//
// Bounded up/down counter with a programmable step, an inclusive window
// [min_val, max_val], and a choice of saturate or wrap behaviour at the
// window edges.
//
// Ports
//   clk         sole clock, all state changes on the rising edge
//   reset_n     asynchronous active-low reset (count, tc, ovf_sticky -> 0)
//   clear       synchronous clear: count -> min_val (or 0 on bad bounds),
//               ovf_sticky -> 0
//   enable      advance the counter by step this cycle
//   load        synchronous load of data, clamped into the window
//   data        load value
//   up          direction, 1 = count up, 0 = count down
//   step        unsigned amount added/subtracted per enabled cycle
//   min_val     lower bound, inclusive
//   max_val     upper bound, inclusive
//   sat_mode    1 = saturate at the bound, 0 = wrap to the opposite bound
//   count       registered counter value
//   tc          registered one-cycle pulse after a boundary event
//   ovf_sticky  set by any boundary event, held until clear or reset
//   cfg_err     combinational, high while min_val > max_val
//
// Per-cycle priority: clear > cfg_err hold > load > enable step > hold.
// ---------------------------------------------------------------------------
module up_down_counter_bounded #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         enable,
    input  logic         load,
    input  logic [N-1:0] data,
    input  logic         up,
    input  logic [N-1:0] step,
    input  logic [N-1:0] min_val,
    input  logic [N-1:0] max_val,
    input  logic         sat_mode,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         ovf_sticky,
    output logic         cfg_err
);

    logic [N-1:0] count_reg, count_next;
    logic         tc_reg, tc_next;
    logic         ovf_reg, ovf_next;

    // Arithmetic is done one bit wider than the counter so that neither the
    // up sum nor the down threshold (min_val + step) can overflow silently.
    logic [N:0]   up_cand;
    logic [N:0]   down_floor;
    logic         up_event;
    logic         down_event;
    logic         out_of_window;
    logic [N-1:0] load_clamped;

    assign cfg_err       = (min_val > max_val);

    assign up_cand       = {1'b0, count_reg} + {1'b0, step};
    assign down_floor    = {1'b0, min_val} + {1'b0, step};

    // With step = 0 neither comparison can fire while count is inside the
    // window, so a zero step naturally holds the count with no event.
    assign up_event      = (up_cand > {1'b0, max_val});
    assign down_event    = ({1'b0, count_reg} < down_floor);

    // Bounds may move at run time, leaving the count stranded outside them.
    assign out_of_window = (count_reg < min_val) || (count_reg > max_val);

    assign load_clamped  = (data < min_val) ? min_val :
                           (data > max_val) ? max_val : data;

    always_comb begin
        count_next = count_reg;
        tc_next    = 1'b0;
        ovf_next   = ovf_reg;

        if (clear) begin
            count_next = cfg_err ? '0 : min_val;
            ovf_next   = 1'b0;
        end else if (cfg_err) begin
            // Bounds are meaningless; freeze everything until fixed or cleared.
            count_next = count_reg;
        end else if (load) begin
            count_next = load_clamped;
        end else if (enable) begin
            if (out_of_window) begin
                // Re-enter the window at the edge the counter is heading from.
                count_next = up ? min_val : max_val;
            end else if (up) begin
                if (up_event) begin
                    count_next = sat_mode ? max_val : min_val;
                    tc_next    = 1'b1;
                    ovf_next   = 1'b1;
                end else begin
                    count_next = up_cand[N-1:0];
                end
            end else begin
                if (down_event) begin
                    count_next = sat_mode ? min_val : max_val;
                    tc_next    = 1'b1;
                    ovf_next   = 1'b1;
                end else begin
                    count_next = count_reg - step;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign count      = count_reg;
    assign tc         = tc_reg;
    assign ovf_sticky = ovf_reg;

endmodule

// File: tb/tb_up_down_counter_bounded.sv
// ---------------------------------------------------------------------------
// tb_up_down_counter_bounded
//
// Self-checking bench for up_down_counter_bounded (N = 8). A table of
// directed vectors with hand-computed expectations is applied first, then a
// few multi-cycle sequences (async reset mid-count, post-reset recovery),
// then randomized traffic. Every cycle is also compared against an
// arithmetic reference model written with plain integers.
// ---------------------------------------------------------------------------
module tb_up_down_counter_bounded;

    localparam int N = 8;

    logic         clk;
    logic         reset_n;
    logic         clear;
    logic         enable;
    logic         load;
    logic [N-1:0] data;
    logic         up;
    logic [N-1:0] step;
    logic [N-1:0] min_val;
    logic [N-1:0] max_val;
    logic         sat_mode;
    logic [N-1:0] count;
    logic         tc;
    logic         ovf_sticky;
    logic         cfg_err;

    up_down_counter_bounded #(.N(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .enable     (enable),
        .load       (load),
        .data       (data),
        .up         (up),
        .step       (step),
        .min_val    (min_val),
        .max_val    (max_val),
        .sat_mode   (sat_mode),
        .count      (count),
        .tc         (tc),
        .ovf_sticky (ovf_sticky),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state.
    int m_count = 0;
    int m_tc    = 0;
    int m_ovf   = 0;

    typedef struct {
        logic         clear;
        logic         load;
        logic         enable;
        logic         up;
        logic         sat;
        logic [N-1:0] data;
        logic [N-1:0] step;
        logic [N-1:0] min_v;
        logic [N-1:0] max_v;
        logic [N-1:0] exp_count;
        logic         exp_tc;
        logic         exp_ovf;
        logic         exp_cfg;
    } vec_t;

    vec_t vec_q[$];

    function automatic void add_vec(int clr, int ld, int en, int u, int s,
                                    int d, int st, int mn, int mx,
                                    int ec, int et, int eo, int ecfg);
        vec_t v;
        v.clear     = 1'(clr);
        v.load      = 1'(ld);
        v.enable    = 1'(en);
        v.up        = 1'(u);
        v.sat       = 1'(s);
        v.data      = 8'(d);
        v.step      = 8'(st);
        v.min_v     = 8'(mn);
        v.max_v     = 8'(mx);
        v.exp_count = 8'(ec);
        v.exp_tc    = 1'(et);
        v.exp_ovf   = 1'(eo);
        v.exp_cfg   = 1'(ecfg);
        vec_q.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Next-state rules expressed directly as integer arithmetic on the window.
    task automatic model_next(output int nc, output int nt, output int no);
        int mn, mx, st, d;
        mn = int'(min_val);
        mx = int'(max_val);
        st = int'(step);
        d  = int'(data);
        nc = m_count;
        nt = 0;
        no = m_ovf;
        if (clear) begin
            nc = (mn > mx) ? 0 : mn;
            no = 0;
        end else if (mn > mx) begin
            nc = m_count;
        end else if (load) begin
            nc = (d < mn) ? mn : ((d > mx) ? mx : d);
        end else if (enable) begin
            if (m_count < mn || m_count > mx) begin
                nc = up ? mn : mx;
            end else if (up) begin
                if (m_count + st > mx) begin
                    nc = sat_mode ? mx : mn;
                    nt = 1;
                    no = 1;
                end else begin
                    nc = m_count + st;
                end
            end else begin
                if (m_count - st < mn) begin
                    nc = sat_mode ? mn : mx;
                    nt = 1;
                    no = 1;
                end else begin
                    nc = m_count - st;
                end
            end
        end
    endtask

    // One clock: advance the model, then compare all outputs just after the edge.
    task automatic tick(input string tag);
        int nc, nt, no;
        model_next(nc, nt, no);
        @(posedge clk);
        #1;
        m_count = nc;
        m_tc    = nt;
        m_ovf   = no;
        check({tag, ".count"},   int'(count),      m_count);
        check({tag, ".tc"},      int'(tc),         m_tc);
        check({tag, ".ovf"},     int'(ovf_sticky), m_ovf);
        check({tag, ".cfg_err"}, int'(cfg_err),    (min_val > max_val) ? 1 : 0);
        $display("%s: clr=%0d ld=%0d en=%0d up=%0d sat=%0d d=%0d st=%0d min=%0d max=%0d -> count=%0d tc=%0d ovf=%0d cfg=%0d",
                 tag, clear, load, enable, up, sat_mode, data, step, min_val, max_val,
                 count, tc, ovf_sticky, cfg_err);
    endtask

    task automatic idle_inputs();
        clear  = 1'b0;
        load   = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b1;
        idle_inputs();
        up       = 1'b1;
        sat_mode = 1'b0;
        data     = '0;
        step     = 8'd1;
        min_val  = '0;
        max_val  = 8'd20;

        // Reset asserted between edges must clear outputs at once.
        #2 reset_n = 1'b0;
        #1;
        check("reset.count", int'(count),      0);
        check("reset.tc",    int'(tc),         0);
        check("reset.ovf",   int'(ovf_sticky), 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        m_count = 0; m_tc = 0; m_ovf = 0;

        // ----------------------------------------------------------- table
        //       clr ld en up sat data st mn mx   cnt tc ovf cfg
        add_vec(1, 1, 1, 1, 0,   0,  3, 5, 20,   5, 0, 0, 0);  // clear wins
        add_vec(0, 1, 1, 1, 0, 200,  3, 5, 20,  20, 0, 0, 0);  // load clamps high
        add_vec(0, 1, 0, 1, 0,  18,  3,10, 20,  18, 0, 0, 0);  // up wrap run
        add_vec(0, 0, 1, 1, 0,  18,  3,10, 20,  10, 1, 1, 0);
        add_vec(0, 0, 1, 1, 0,  18,  3,10, 20,  13, 0, 1, 0);
        add_vec(0, 0, 1, 1, 0,  18,  3,10, 20,  16, 0, 1, 0);
        add_vec(0, 0, 1, 1, 0,  18,  3,10, 20,  19, 0, 1, 0);
        add_vec(0, 0, 1, 1, 0,  18,  3,10, 20,  10, 1, 1, 0);
        add_vec(1, 0, 0, 1, 0,   0,  3,10, 20,  10, 0, 0, 0);  // clear sticky
        add_vec(0, 1, 0, 0, 1,  15,  4,10, 20,  15, 0, 0, 0);  // down saturate
        add_vec(0, 0, 1, 0, 1,  15,  4,10, 20,  11, 0, 0, 0);
        add_vec(0, 0, 1, 0, 1,  15,  4,10, 20,  10, 1, 1, 0);
        add_vec(0, 0, 1, 0, 1,  15,  4,10, 20,  10, 1, 1, 0);
        add_vec(0, 0, 1, 0, 1,  15,  0,10, 20,  10, 0, 1, 0);  // step 0 holds
        add_vec(0, 1, 0, 1, 0,  15,  3,10, 20,  15, 0, 1, 0);  // out-of-range
        add_vec(0, 0, 1, 1, 0,  15,  3,10, 12,  10, 0, 1, 0);
        add_vec(1, 0, 0, 1, 0,   0,  1, 7,  7,   7, 0, 0, 0);  // min == max
        add_vec(0, 0, 1, 1, 0,   0,  1, 7,  7,   7, 1, 1, 0);
        add_vec(0, 0, 1, 0, 0,   0,  1, 7,  7,   7, 1, 1, 0);
        add_vec(0, 0, 1, 1, 0,   0,  1,30, 20,   7, 0, 1, 1);  // cfg error
        add_vec(0, 1, 0, 1, 0,  50,  1,30, 20,   7, 0, 1, 1);
        add_vec(1, 0, 0, 1, 0,   0,  1,30, 20,   0, 0, 0, 1);
        add_vec(0, 1, 0, 1, 0,   3,  1, 5, 20,   5, 0, 0, 0);  // load clamps low

        for (int i = 0; i < vec_q.size(); i++) begin
            clear    = vec_q[i].clear;
            load     = vec_q[i].load;
            enable   = vec_q[i].enable;
            up       = vec_q[i].up;
            sat_mode = vec_q[i].sat;
            data     = vec_q[i].data;
            step     = vec_q[i].step;
            min_val  = vec_q[i].min_v;
            max_val  = vec_q[i].max_v;
            tick($sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_count", i), int'(count),      int'(vec_q[i].exp_count));
            check($sformatf("vec%0d.tbl_tc", i),    int'(tc),         int'(vec_q[i].exp_tc));
            check($sformatf("vec%0d.tbl_ovf", i),   int'(ovf_sticky), int'(vec_q[i].exp_ovf));
            check($sformatf("vec%0d.tbl_cfg", i),   int'(cfg_err),    int'(vec_q[i].exp_cfg));
        end

        // ------------------------------------- async reset mid-count, tc live
        idle_inputs();
        min_val = 8'd10; max_val = 8'd20; step = 8'd3; up = 1'b1; sat_mode = 1'b0;
        data = 8'd19; load = 1'b1;
        tick("arst.load");
        load = 1'b0; enable = 1'b1;
        tick("arst.wrap");
        check("arst.tc_before", int'(tc), 1);
        #1 reset_n = 1'b0;
        #1;
        check("arst.count", int'(count),      0);
        check("arst.tc",    int'(tc),         0);
        check("arst.ovf",   int'(ovf_sticky), 0);
        enable = 1'b0;
        #1 reset_n = 1'b1;
        m_count = 0; m_tc = 0; m_ovf = 0;

        // Count holds at 0 (below min) until enabled; then re-enters at max going down.
        tick("post_rst.hold");
        check("post_rst.hold_count", int'(count), 0);
        up = 1'b0; enable = 1'b1;
        tick("post_rst.down");
        check("post_rst.down_count", int'(count), 20);
        check("post_rst.down_tc",    int'(tc),    0);

        // ----------------------------------------------------------- random
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) begin
                int mn, mx, tmp;
                mn = $urandom_range(0, 120);
                mx = mn + $urandom_range(0, 120);
                if ($urandom_range(0, 9) == 0) begin
                    tmp = mn; mn = mx; mx = tmp;
                end
                min_val = 8'(mn);
                max_val = 8'(mx);
            end
            clear    = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 9) == 0);
            enable   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) up = ~up;
            if ($urandom_range(0, 15) == 0) sat_mode = ~sat_mode;
            data     = 8'($urandom_range(0, 255));
            step     = 8'($urandom_range(0, 40));
            tick($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
